// File: rtl/seq_gen_if.sv
// Bundles the control inputs and serial/status outputs of the pattern sequence generator.
interface seq_gen_if;
    logic       start;
    logic       pat_sel;
    logic [3:0] reps;
    logic [1:0] gap_len;
    logic       stop;
    logic       data;
    logic       data_valid;
    logic       busy;
    logic       frame_done;
    logic       done;
    logic [7:0] frame_count;

    modport master (
        output start, pat_sel, reps, gap_len, stop,
        input  data, data_valid, busy, frame_done, done, frame_count
    );

    modport slave (
        input  start, pat_sel, reps, gap_len, stop,
        output data, data_valid, busy, frame_done, done, frame_count
    );
endinterface

// File: rtl/seq_gen.sv
// Serial frame generator: sends 5-bit patterns MSB first, repeated with optional idle gaps,
// finite or continuous until stop. All outputs are registered from the next-state decode.
module seq_gen (
    input  logic     clock,
    input  logic     reset,
    seq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    state_t     state_r, state_s;
    logic [2:0] bit_r, bit_s;
    logic [1:0] gap_cnt_r, gap_cnt_s;
    logic [3:0] sent_r, sent_s;
    logic       stop_pend_r, stop_pend_s;
    logic       pat_r, pat_s;
    logic [3:0] reps_r, reps_s;
    logic [1:0] gap_len_r, gap_len_s;
    logic       last_s;

    logic       data_r, valid_r, busy_r, frame_done_r, done_r;
    logic [7:0] frame_count_r;

    function automatic logic pattern_bit(input logic sel, input logic [2:0] idx);
        logic [4:0] pat;
        pat = sel ? 5'b10001 : 5'b10101;
        return pat[idx];
    endfunction

    // Next-state logic: frame sequencing, gap timing, stop handling and parameter latching.
    always_comb begin
        state_s     = state_r;
        bit_s       = bit_r;
        gap_cnt_s   = gap_cnt_r;
        sent_s      = sent_r;
        stop_pend_s = stop_pend_r;
        pat_s       = pat_r;
        reps_s      = reps_r;
        gap_len_s   = gap_len_r;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                bit_s = 3'd4;
                if (bus.start) begin
                    state_s     = SEND;
                    sent_s      = 4'd0;
                    stop_pend_s = 1'b0;
                    pat_s       = bus.pat_sel;
                    reps_s      = bus.reps;
                    gap_len_s   = bus.gap_len;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bit_r == 3'd0) begin
                    // A stop seen anywhere in this frame makes it the final one.
                    last_s = stop_pend_r | bus.stop |
                             ((reps_r != 4'd0) && (({1'b0, sent_r} + 5'd1) == {1'b0, reps_r}));
                    sent_s = (sent_r == 4'd15) ? sent_r : sent_r + 4'd1;
                    bit_s  = 3'd4;
                    if (last_s) begin
                        state_s = IDLE;
                    end else if (gap_len_r != 2'd0) begin
                        state_s   = GAP;
                        gap_cnt_s = gap_len_r - 2'd1;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    bit_s       = bit_r - 3'd1;
                    stop_pend_s = stop_pend_r | bus.stop;
                end
            end
            GAP: begin
                if (bus.stop) begin
                    state_s = IDLE;
                end else if (gap_cnt_r == 2'd0) begin
                    state_s = SEND;
                end else begin
                    gap_cnt_s = gap_cnt_r - 2'd1;
                end
            end
            default: begin
                state_s = IDLE;
                bit_s   = 3'd4;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_r       <= 3'd4;
            gap_cnt_r   <= 2'd0;
            sent_r      <= 4'd0;
            stop_pend_r <= 1'b0;
            pat_r       <= 1'b0;
            reps_r      <= 4'd0;
            gap_len_r   <= 2'd0;
        end else begin
            state_r     <= state_s;
            bit_r       <= bit_s;
            gap_cnt_r   <= gap_cnt_s;
            sent_r      <= sent_s;
            stop_pend_r <= stop_pend_s;
            pat_r       <= pat_s;
            reps_r      <= reps_s;
            gap_len_r   <= gap_len_s;
        end
    end

    // Output registers decoded from the next state so bit 4 appears right after the accepting edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r        <= 1'b0;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            done_r        <= 1'b0;
            frame_count_r <= 8'd0;
        end else begin
            valid_r      <= (state_s == SEND);
            data_r       <= (state_s == SEND) ? pattern_bit(pat_s, bit_s) : 1'b0;
            busy_r       <= (state_s != IDLE);
            frame_done_r <= (state_s == SEND) && (bit_s == 3'd0);
            done_r       <= (state_r != IDLE) && (state_s == IDLE);
            if ((state_r == IDLE) && bus.start) begin
                frame_count_r <= 8'd0;
            end else if ((state_r == SEND) && (bit_r == 3'd0) && (frame_count_r != 8'd255)) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign bus.data        = data_r;
    assign bus.data_valid  = valid_r;
    assign bus.busy        = busy_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.done        = done_r;
    assign bus.frame_count = frame_count_r;
endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected bits are queued as stimulus is driven and
// compared against the bits captured while data_valid is high.
module tb_seq_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;

    seq_gen_if bus();
    seq_gen dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_q[$];
    bit   obs_q[$];
    int   n_done, n_fd, n_busy, n_junk, n_det;
    logic [4:0] det_sr;
    logic last_busy, last_done;

    // Sample the current cycle at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clock);
        last_busy = bus.busy;
        last_done = bus.done;
        if (bus.data_valid === 1'b1) begin
            obs_q.push_back(bus.data);
            det_sr = {det_sr[3:0], bus.data};
            if (det_sr == 5'b10101) n_det++;
        end else if (bus.data !== 1'b0) begin
            n_junk++;
        end
        if (bus.done === 1'b1) n_done++;
        if (bus.frame_done === 1'b1) n_fd++;
        if (bus.busy === 1'b1) n_busy++;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        n_done = 0; n_fd = 0; n_busy = 0; n_det = 0;
        det_sr = 5'd0;
    endtask

    function automatic void push_frame(input bit sel);
        bit [4:0] p;
        p = sel ? 5'b10001 : 5'b10101;
        for (int i = 4; i >= 0; i--) exp_q.push_back(p[i]);
    endfunction

    task automatic start_tx(input bit p, input bit [3:0] r, input bit [1:0] g);
        bus.pat_sel = p; bus.reps = r; bus.gap_len = g; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            step();
            if (last_busy !== 1'b1) break;
        end
        n_tests++;
        if (k == budget) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_tests++;
        if ({bus.data, bus.data_valid, bus.busy, bus.frame_done, bus.done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {bus.data, bus.data_valid, bus.busy, bus.frame_done, bus.done});
        end
        n_tests++;
        if (bus.frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, expected 0", bus.frame_count);
        end
        @(posedge clock); #1;
        step();
        reset = 1'b0;
        clear_obs();
        repeat (3) step();
        n_tests++;
        if (n_busy !== 0 || n_done !== 0 || obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %0d done %0d bits %0d, expected all 0", n_busy, n_done, obs_q.size());
        end
    endtask

    task automatic test_single();
        clear_obs();
        start_tx(1'b0, 4'd1, 2'd0);
        push_frame(1'b0);
        n_tests++;
        if (bus.data_valid !== 1'b1 || bus.data !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: valid %b data %b, expected 1 1", bus.data_valid, bus.data);
        end
        wait_idle(20, "single");
        n_tests++;
        if (last_done !== 1'b1 || n_done !== 1 || n_fd !== 1 || n_busy !== 5) begin
            n_fail++;
            $display("FAIL single_status: done_at_end %b dones %0d frame_dones %0d busy %0d, expected 1 1 1 5",
                     last_done, n_done, n_fd, n_busy);
        end
        n_tests++;
        if (bus.frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_count: got %0d, expected 1", bus.frame_count);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL single_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gapped();
        clear_obs();
        start_tx(1'b1, 4'd3, 2'd2);
        repeat (3) push_frame(1'b1);
        wait_idle(40, "gapped");
        n_tests++;
        if (n_busy !== 19 || n_done !== 1 || n_fd !== 3 || bus.frame_count !== 8'd3) begin
            n_fail++;
            $display("FAIL gapped_status: busy %0d dones %0d frame_dones %0d count %0d, expected 19 1 3 3",
                     n_busy, n_done, n_fd, bus.frame_count);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL gapped_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gapped_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        start_tx(1'b0, 4'd2, 2'd0);
        repeat (2) push_frame(1'b0);
        wait_idle(30, "b2b");
        n_tests++;
        if (n_busy !== 10 || n_det !== 2 || bus.frame_count !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_status: busy %0d detections %0d count %0d, expected 10 2 2",
                     n_busy, n_det, bus.frame_count);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_continuous_stop();
        clear_obs();
        start_tx(1'b0, 4'd0, 2'd1);
        repeat (4) push_frame(1'b0);
        repeat (20) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        wait_idle(30, "cont_stop");
        n_tests++;
        if (n_done !== 1 || bus.frame_count !== 8'd4 || last_done !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_stop_status: dones %0d count %0d done_at_end %b, expected 1 4 1",
                     n_done, bus.frame_count, last_done);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL cont_stop_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL cont_stop_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_obs();
        start_tx(1'b1, 4'd0, 2'd3);
        push_frame(1'b1);
        repeat (5) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_stop: done %b busy %b count %0d, expected 1 0 1",
                     bus.done, bus.busy, bus.frame_count);
        end
        wait_idle(10, "gap_stop");
        n_tests++;
        if (obs_q.size() !== 5 || n_done !== 1) begin
            n_fail++;
            $display("FAIL gap_stop_bits: bits %0d dones %0d, expected 5 1", obs_q.size(), n_done);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        start_tx(1'b0, 4'd1, 2'd0);
        exp_q.push_back(1'b1);
        step();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.data, bus.data_valid, bus.busy, bus.frame_done, bus.done} !== 5'b0 ||
            bus.frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b count %0d, expected 00000 0",
                     {bus.data, bus.data_valid, bus.busy, bus.frame_done, bus.done}, bus.frame_count);
        end
        repeat (2) step();
        reset = 1'b0;
        bus.pat_sel = 1'b0; bus.reps = 4'd1; bus.gap_len = 2'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        push_frame(1'b0);
        n_tests++;
        if (bus.data_valid !== 1'b1 || bus.frame_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: valid %b count %0d, expected 1 0", bus.data_valid, bus.frame_count);
        end
        wait_idle(20, "reset_mid");
        n_tests++;
        if (n_done !== 1 || bus.frame_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_mid_status: dones %0d count %0d, expected 1 1", n_done, bus.frame_count);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL reset_mid_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        clear_obs();
        start_tx(1'b0, 4'd2, 2'd0);
        repeat (2) push_frame(1'b0);
        repeat (2) step();
        bus.pat_sel = 1'b1; bus.reps = 4'd5; bus.gap_len = 2'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_idle(30, "ignored");
        n_tests++;
        if (n_busy !== 10 || n_done !== 1 || bus.frame_count !== 8'd2) begin
            n_fail++;
            $display("FAIL ignored_status: busy %0d dones %0d count %0d, expected 10 1 2",
                     n_busy, n_done, bus.frame_count);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL ignored_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignored_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_on_done();
        clear_obs();
        start_tx(1'b0, 4'd1, 2'd0);
        push_frame(1'b0);
        repeat (5) step();
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle: got %b, expected 1", bus.done);
        end
        bus.pat_sel = 1'b1; bus.reps = 4'd1; bus.gap_len = 2'd0;
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        push_frame(1'b1);
        wait_idle(20, "start_on_done");
        n_tests++;
        if (n_done !== 2 || bus.frame_count !== 8'd1 || n_fd !== 2) begin
            n_fail++;
            $display("FAIL start_on_done_status: dones %0d count %0d frame_dones %0d, expected 2 1 2",
                     n_done, bus.frame_count, n_fd);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL start_on_done_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL start_on_done_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_obs();
        start_tx(1'b0, 4'd0, 2'd0);
        repeat (260) push_frame(1'b0);
        repeat (1297) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        wait_idle(20, "saturation");
        n_tests++;
        if (bus.frame_count !== 8'd255 || n_fd !== 260) begin
            n_fail++;
            $display("FAIL saturation_count: count %0d frame_dones %0d, expected 255 260", bus.frame_count, n_fd);
        end
        n_tests++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL saturation_len: got %0d bits, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL saturation_bit%0d: got %b, expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (n_junk !== 0) begin
            n_fail++;
            $display("FAIL idle_data: data high without valid in %0d cycles, expected 0", n_junk);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.pat_sel = 1'b0; bus.reps = 4'd0; bus.gap_len = 2'd0;
        n_junk = 0;
        clear_obs();
        test_reset();
        n_junk = 0;
        test_single();
        test_gapped();
        test_back_to_back();
        test_continuous_stop();
        test_reset_mid();
        test_ignored_start();
        test_start_on_done();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 clock  input  1  rising-edge clock for all state and output registers.
REQ-002 reset  input  1  asynchronous, active-high reset; clears all state and outputs immediately.
REQ-003 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-004 pat_sel  input  1  pattern select: 0 = 10101, 1 = 10001; latched on accepted start.
REQ-005 reps  input  4  number of frames to send, 1..15; 0 = continuous until stop; latched on accepted start.
REQ-006 gap_len  input  2  idle cycles inserted between frames, 0..3; latched on accepted start.
REQ-007 stop  input  1  request to end the transmission early; sampled only when busy.
REQ-008 data  output  1  serial pattern bit, MSB first; 0 whenever data_valid = 0.
REQ-009 data_valid  output  1  high for exactly the cycles in which data carries a pattern bit.
REQ-010 busy  output  1  high in SEND and GAP states.
REQ-011 frame_done  output  1  high in the same cycle as the last bit (bit 0) of every frame.
REQ-012 done  output  1  one-cycle pulse in the cycle after the final frame ends or the stop terminates.
REQ-013 frame_count  output  8  frames completed since the last accepted start; saturates at 255.

Function
REQ-014 All outputs shall be registered; no combinational path from any input to any output.
REQ-015 The FSM shall have states IDLE, SEND and GAP; the bit index runs 4..0 within SEND.
REQ-016 IDLE with start = 1 at a rising edge shall latch pat_sel, reps and gap_len, clear frame_count, and enter SEND with bit index 4.
REQ-017 Data bit 4 (always 1) shall appear with data_valid = 1 in the cycle immediately after the accepting edge, giving a latency of 1 cycle.
REQ-018 Each bit shall be held for exactly one cycle; a frame occupies 5 consecutive data_valid cycles.
REQ-019 Frame bits shall be 1,0,1,0,1 for pat_sel = 0 and 1,0,0,0,1 for pat_sel = 1.
REQ-020 On bit 0, frame_done = 1; frame_count shall increment at the following edge, saturating at 255.
REQ-021 After bit 0 with frames remaining and gap_len > 0: enter GAP for gap_len cycles (data = 0, data_valid = 0, busy = 1), then SEND at bit 4.
REQ-022 After bit 0 with frames remaining and gap_len = 0: the next frame's bit 4 shall follow in the very next cycle, back to back.
REQ-023 After bit 0 of the final frame (frames sent = reps, reps != 0): go to IDLE, with done = 1 and busy = 0 in that next cycle.
REQ-024 With reps = 0, frames shall repeat indefinitely until stop.
REQ-025 stop in SEND shall not truncate the frame: finish through bit 0, then behave as the final frame (REQ-023).
REQ-026 stop in GAP shall go to IDLE at the next edge, with done = 1 in that cycle.
REQ-027 start while busy shall be ignored; a changing pat_sel, reps or gap_len while busy shall have no effect.
REQ-028 start and stop asserted together in IDLE: start shall be accepted and stop ignored.
REQ-029 start sampled in the same cycle as the done pulse (state IDLE) shall be accepted normally.
REQ-030 The internal frame counter shall be at least 4 bits and compared against the latched reps; no wrap-around shall occur in finite mode.

Reset
REQ-031 Asserting reset shall force IDLE, bit index 4, and data, data_valid, busy, frame_done and done to 0, with frame_count = 0, regardless of the clock.
REQ-032 Reset asserted mid-frame shall abort immediately with no done pulse; after deassertion, the block shall wait for a new start.
REQ-033 The first rising edge after reset deasserts shall be able to accept start.

Verification
REQ-034 Single frame: pat_sel = 0, reps = 1, gap_len = 0, start pulse -> data 1,0,1,0,1 with data_valid high for 5 cycles, frame_done on the 5th, done on the 6th, frame_count = 1.
REQ-035 Gapped repeat: pat_sel = 1, reps = 3, gap_len = 2 -> 10001, 2 idle, 10001, 2 idle, 10001; 19 busy cycles; frame_count = 3; one done pulse.
REQ-036 Back to back: pat_sel = 0, reps = 2, gap_len = 0 -> 10 consecutive valid bits 1010110101; a 10101 detector driven from data/data_valid shall report 2 detections.
REQ-037 Continuous with stop: reps = 0, gap_len = 1, stop raised at frame 4 bit 2 -> frame 4 completes, done follows, frame_count = 4; stop in GAP -> done on the next cycle.
REQ-038 Reset mid-frame: reset at bit 3 of frame 1 -> all outputs 0 at once, no done pulse; start after release -> a correct fresh frame with frame_count restarting from 0.
REQ-039 Ignored start: start pulsed during SEND with a different pat_sel -> the sequence is unchanged and no extra frame is sent.
